// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative XLEN x XLEN -> 2*XLEN multiplier, STEP multiplier bits per CALC cycle
//   Optional build macro ALU_MUL_EARLY_EXIT_EN: leave CALC as soon as the remaining multiplier is zero.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     flush_i             cancel any operation, return to IDLE next edge
//     mul_valid_i/_ready_o request handshake (ready only in IDLE with flush_i low)
//     rs1/rs2_signed_i    per-operand two's complement flags
//     rs1_data_i          multiplicand, rs2_data_i multiplier
//     out_valid_o/ready_i result handshake
//     mul_out_o           full 2*XLEN product, held until the next result
module alu_mul_iter #(
    parameter int XLEN = 64,
    parameter int STEP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              mul_valid_i,
    output logic              mul_ready_o,
    input  logic              rs1_signed_i,
    input  logic              rs2_signed_i,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [2*XLEN-1:0] mul_out_o
);
    localparam int N  = XLEN / STEP;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state, state_nxt;
    logic [2*XLEN-1:0]   acc, mcand, partial;
    logic [XLEN-1:0]     mplier, mplier_nxt, rs1_mag, rs2_mag;
    logic [CW-1:0]       cnt;
    logic                neg, rs1_neg, rs2_neg, accept, last, calc_done;

    always_comb begin
        rs1_neg    = rs1_signed_i && rs1_data_i[XLEN-1];
        rs2_neg    = rs2_signed_i && rs2_data_i[XLEN-1];
        rs1_mag    = rs1_neg ? -rs1_data_i : rs1_data_i;
        rs2_mag    = rs2_neg ? -rs2_data_i : rs2_data_i;
        accept     = mul_valid_i && mul_ready_o;
        // mcand is pre-shifted each cycle, so the partial product needs no extra shift
        partial    = mcand * {{(2*XLEN-STEP){1'b0}}, mplier[STEP-1:0]};
        mplier_nxt = mplier >> STEP;
        last       = cnt == CW'(N - 1);
`ifdef ALU_MUL_EARLY_EXIT_EN
        calc_done  = last || (mplier_nxt == '0);
`else
        calc_done  = last;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? CALC : IDLE;
            CALC:    state_nxt = calc_done ? FIX : CALC;
            FIX:     state_nxt = DONE;
            default: state_nxt = out_ready_i ? IDLE : DONE;
        endcase
    end

    always_comb begin
        mul_ready_o = (state == IDLE) && !flush_i;
        out_valid_o = state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            mul_out_o <= '0;
        end else if (!flush_i) begin
            if (accept) begin
                acc    <= '0;
                mcand  <= {{XLEN{1'b0}}, rs1_mag};
                mplier <= rs2_mag;
                cnt    <= '0;
                neg    <= rs1_neg ^ rs2_neg;
            end
            if (state == CALC) begin
                acc    <= acc + partial;
                mcand  <= mcand << STEP;
                mplier <= mplier_nxt;
                cnt    <= cnt + CW'(1);
            end
            if (state == FIX) mul_out_o <= neg ? -acc : acc;
        end
    end
endmodule
